// File: rtl/jtcop_dump_trigger.sv
// jtcop_dump_trigger: frame-windowed debug capture controller.
// Counts vertical-sync falling edges and opens a capture window of
// programmable length at a programmed frame, periodically, or after a
// download completes. Drives per-channel capture enables.
//
// state | meaning
// IDLE  | not armed; configuration not latched
// WAIT  | armed, waiting for the trigger frame / download end
// CAPT  | capture window open
// DONE  | one-shot window completed; done held until re-arm
module jtcop_dump_trigger #(
  parameter int FW = 32,
  parameter int LW = 8,
  parameter int CH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          led,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] start,
  input  logic [FW-1:0] period,
  input  logic [LW-1:0] len,
  input  logic [CH-1:0] ch_mask,
  input  logic          arm,
  output logic [FW-1:0] frame_cnt,
  output logic          dump_on,
  output logic [CH-1:0] dump_ch,
  output logic          win_start,
  output logic          win_end,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] M_ONESHOT  = 2'd0;
  localparam logic [1:0] M_PERIODIC = 2'd1;
  localparam logic [1:0] M_DOWNLOAD = 2'd2;
  localparam logic [1:0] M_DISABLED = 2'd3;

  state_t        state_q;
  logic          vs_q, led_q;
  logic [FW-1:0] fc_q;
  logic [FW-1:0] tgt_q;
  logic [FW-1:0] period_s_q;
  logic [LW-1:0] len_s_q;
  logic [LW-1:0] wc_q;
  logic [CH-1:0] mask_s_q;
  logic [1:0]    mode_s_q;
  logic          dl_seen_q;
  logic          dump_on_q, win_start_q, win_end_q, busy_q, done_q;
  logic [CH-1:0] dump_ch_q;

  logic fall_d, dl_end_d, wait_hit_d, close_d, rehit_d, open_d, latch_d;

  // Edge events and trigger decisions for the current cycle. Compares use
  // the frame count before the increment caused by this fall.
  always_comb begin
    fall_d     = vs_q & ~vs;
    dl_end_d   = led_q & ~led;
    wait_hit_d = (mode_s_q == M_DOWNLOAD) ? (fall_d & dl_seen_q)
                                          : (fall_d & (fc_q == tgt_q));
    close_d    = fall_d & (len_s_q != '0) & (wc_q == LW'(1));
    rehit_d    = close_d & (mode_s_q == M_PERIODIC) & (period_s_q != '0)
                 & (fc_q == tgt_q);
    // An arm pulse in WAIT/CAPT is an abort, so it always beats a trigger.
    open_d     = ~arm & (((state_q == S_WAIT) & wait_hit_d) |
                         ((state_q == S_CAPT) & rehit_d));
    latch_d    = arm & (mode != M_DISABLED) &
                 ((state_q == S_IDLE) | (state_q == S_DONE));
  end

  // Frame counter, edge detectors, and the capture FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      led_q       <= 1'b0;
      fc_q        <= '0;
      tgt_q       <= '0;
      period_s_q  <= '0;
      len_s_q     <= '0;
      wc_q        <= '0;
      mask_s_q    <= '0;
      mode_s_q    <= '0;
      dl_seen_q   <= 1'b0;
      dump_on_q   <= 1'b0;
      dump_ch_q   <= '0;
      win_start_q <= 1'b0;
      win_end_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      vs_q        <= vs;
      led_q       <= led;
      win_start_q <= 1'b0;
      win_end_q   <= 1'b0;
      if (fall_d) fc_q <= fc_q + FW'(1);

      // Window opening is shared between the first trigger and a periodic
      // retrigger that lands on the same fall as the close.
      if (open_d) begin
        state_q     <= S_CAPT;
        wc_q        <= len_s_q;
        win_start_q <= 1'b1;
        dump_on_q   <= 1'b1;
        dump_ch_q   <= mask_s_q;
        busy_q      <= 1'b1;
        dl_seen_q   <= 1'b0;
        if (mode_s_q == M_PERIODIC) tgt_q <= tgt_q + period_s_q;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (latch_d) begin
            state_q    <= S_WAIT;
            mode_s_q   <= mode;
            period_s_q <= period;
            len_s_q    <= len;
            mask_s_q   <= ch_mask;
            tgt_q      <= start;
            dl_seen_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (arm) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            dl_seen_q <= 1'b0;
          end else if (!open_d && mode_s_q == M_DOWNLOAD && dl_end_d) begin
            dl_seen_q <= 1'b1;
          end
        end
        S_CAPT: begin
          if (arm) begin
            state_q   <= S_IDLE;
            dump_on_q <= 1'b0;
            dump_ch_q <= '0;
            win_end_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (close_d) begin
            win_end_q <= 1'b1;
            if (!rehit_d) begin
              dump_on_q <= 1'b0;
              dump_ch_q <= '0;
              if (mode_s_q == M_PERIODIC && period_s_q != '0) begin
                state_q <= S_WAIT;
              end else begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end else if (fall_d && len_s_q != '0) begin
            wc_q <= wc_q - LW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_cnt = fc_q;
  assign dump_on   = dump_on_q;
  assign dump_ch   = dump_ch_q;
  assign win_start = win_start_q;
  assign win_end   = win_end_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_jtcop_dump_trigger.sv
// Bench for jtcop_dump_trigger: table-driven scenarios plus hand sequences,
// with expected window-start frames queued and checked as windows open.
module tb_jtcop_dump_trigger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0, led = 1'b0, arm = 1'b0, arm4 = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] start = '0, period = '0;
  logic [3:0]  start4 = '0, period4 = '0;
  logic [7:0]  len = '0;
  logic [3:0]  ch_mask = '0;

  logic [31:0] frame_cnt;
  logic        dump_on, win_start, win_end, busy, done;
  logic [3:0]  dump_ch;
  logic [3:0]  frame_cnt4;
  logic        dump_on4, win_start4, win_end4, busy4, done4;
  logic [3:0]  dump_ch4;

  always #5 clk = ~clk;

  jtcop_dump_trigger #(.FW(32), .LW(8), .CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .led(led), .mode(mode),
    .start(start), .period(period), .len(len), .ch_mask(ch_mask), .arm(arm),
    .frame_cnt(frame_cnt), .dump_on(dump_on), .dump_ch(dump_ch),
    .win_start(win_start), .win_end(win_end), .busy(busy), .done(done));

  jtcop_dump_trigger #(.FW(4), .LW(8), .CH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .led(led), .mode(mode),
    .start(start4), .period(period4), .len(len), .ch_mask(ch_mask), .arm(arm4),
    .frame_cnt(frame_cnt4), .dump_on(dump_on4), .dump_ch(dump_ch4),
    .win_start(win_start4), .win_end(win_end4), .busy(busy4), .done(done4));

  int total = 0, bad = 0;
  int ws_cnt = 0, we_cnt = 0, coin_cnt = 0, ws4_cnt = 0, dump_gap = 0;
  logic [31:0] last_we_fc = '0;
  logic [3:0]  cur_mask = '0;
  logic        watch_dump = 1'b0;
  logic [31:0] sb_q[$];
  logic [3:0]  sb4_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One video frame; the fall is seen on the third clock edge.
  task automatic frame();
    vs = 1'b1;
    tick(); tick();
    vs = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; arm4 = 1'b0; vs = 1'b0; led = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    ws_cnt = 0; we_cnt = 0; coin_cnt = 0; ws4_cnt = 0; last_we_fc = '0;
    dump_gap = 0; watch_dump = 1'b0;
    sb_q.delete(); sb4_q.delete();
  endtask

  // Scoreboard: every window opening must match the next queued frame count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_start) begin
        ws_cnt++;
        chk("ws_dump_ch", {28'd0, dump_ch}, {28'd0, cur_mask});
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_win_start: frame_cnt=%0d want no window", frame_cnt);
        end else chk("ws_frame", frame_cnt, sb_q.pop_front());
      end
      if (win_end) begin
        we_cnt++;
        last_we_fc = frame_cnt;
      end
      if (win_start && win_end) coin_cnt++;
      if (watch_dump && !dump_on) dump_gap++;
      if (win_start4) begin
        ws4_cnt++;
        if (sb4_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_win_start4: frame_cnt4=%0d want no window", frame_cnt4);
        end else chk("ws4_frame", {28'd0, frame_cnt4}, {28'd0, sb4_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] start;
    logic [31:0] period;
    logic [7:0]  len;
    logic [3:0]  mask;
    int          nfr;
    int          e_ws;
    int          e_we;
    logic [31:0] e_ws_fc;
    logic [31:0] e_we_fc;
    logic        e_done;
    logic        e_busy;
    logic        e_dump;
  } vec_t;

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenarios armed at frame 1; config inputs scrambled right after arm.
    vt[0] = '{2'd0, 32'd5, 32'd0, 8'd3, 4'b0101, 10, 1, 1, 32'd6, 32'd9, 1'b1, 1'b0, 1'b0};
    vt[1] = '{2'd0, 32'd3, 32'd0, 8'd0, 4'b1111,  8, 1, 0, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1};
    vt[2] = '{2'd3, 32'd2, 32'd0, 8'd2, 4'b0011,  6, 0, 0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{2'd1, 32'd2, 32'd0, 8'd2, 4'b0011,  8, 1, 1, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0};
    vt[4] = '{2'd0, 32'd1, 32'd0, 8'd1, 4'b1000,  5, 1, 1, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0};
    vt[5] = '{2'd2, 32'd1, 32'd0, 8'd2, 4'b0110,  5, 0, 0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0};

    // Reset held with vs toggling, then release while vs is high.
    rst_n = 1'b0;
    frame(); frame();
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    chk("rst_dump_on", {31'd0, dump_on}, 32'd0);
    chk("rst_dump_ch", {28'd0, dump_ch}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pulses", {30'd0, win_start, win_end}, 32'd0);
    vs = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rel_no_count", frame_cnt, 32'd0);
    vs = 1'b0;
    tick(); tick();
    chk("rel_first_fall", frame_cnt, 32'd1);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      frame();
      mode = vt[i].mode; start = vt[i].start; period = vt[i].period;
      len = vt[i].len; ch_mask = vt[i].mask; cur_mask = vt[i].mask;
      if (vt[i].e_ws > 0) sb_q.push_back(vt[i].e_ws_fc);
      pulse_arm();
      mode = 2'd3; start = 32'hFFFF_FFF0; period = 32'd7; len = 8'd9;
      ch_mask = ~vt[i].mask;
      repeat (vt[i].nfr) frame();
      chk($sformatf("r%0d_ws_cnt", i), ws_cnt, vt[i].e_ws);
      chk($sformatf("r%0d_we_cnt", i), we_cnt, vt[i].e_we);
      chk($sformatf("r%0d_we_fc", i), last_we_fc, vt[i].e_we_fc);
      chk($sformatf("r%0d_done", i), {31'd0, done}, {31'd0, vt[i].e_done});
      chk($sformatf("r%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
      chk($sformatf("r%0d_dump_on", i), {31'd0, dump_on}, {31'd0, vt[i].e_dump});
      chk($sformatf("r%0d_dump_ch", i), {28'd0, dump_ch},
          {28'd0, vt[i].e_dump ? vt[i].mask : 4'b0000});
      chk($sformatf("r%0d_frame_cnt", i), frame_cnt, 32'(1 + vt[i].nfr));
      chk($sformatf("r%0d_sb_empty", i), sb_q.size(), 0);
    end

    // Periodic with back-to-back windows, then abort while capturing.
    do_reset();
    frame();
    mode = 2'd1; start = 32'd2; period = 32'd4; len = 8'd4;
    ch_mask = 4'b1010; cur_mask = 4'b1010;
    sb_q.push_back(32'd3); sb_q.push_back(32'd7); sb_q.push_back(32'd11);
    pulse_arm();
    ch_mask = 4'b0000; period = 32'd1;
    frame(); frame();
    chk("p_dump_rise", {31'd0, dump_on}, 32'd1);
    watch_dump = 1'b1;
    repeat (9) frame();
    watch_dump = 1'b0;
    chk("p_frame_cnt", frame_cnt, 32'd12);
    chk("p_dump_gap", dump_gap, 0);
    chk("p_coincident", coin_cnt, 2);
    chk("p_ws_cnt", ws_cnt, 3);
    chk("p_we_cnt", we_cnt, 2);
    pulse_arm();
    chk("p_abort_dump_on", {31'd0, dump_on}, 32'd0);
    chk("p_abort_dump_ch", {28'd0, dump_ch}, 32'd0);
    chk("p_abort_win_end", {31'd0, win_end}, 32'd1);
    chk("p_abort_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("p_abort_we_cnt", we_cnt, 3);
    frame(); frame();
    chk("p_idle_after_abort", ws_cnt, 3);

    // Download-end trigger.
    do_reset();
    frame();
    led = 1'b1; mode = 2'd2; len = 8'd2; ch_mask = 4'b1100; cur_mask = 4'b1100;
    pulse_arm();
    repeat (3) frame();
    chk("d_busy_wait", {31'd0, busy}, 32'd1);
    chk("d_no_early", ws_cnt, 0);
    sb_q.push_back(32'd5);
    led = 1'b0;
    tick(); tick();
    frame();
    chk("d_dump_on", {31'd0, dump_on}, 32'd1);
    repeat (3) frame();
    chk("d_done", {31'd0, done}, 32'd1);
    chk("d_busy", {31'd0, busy}, 32'd0);
    chk("d_we_fc", last_we_fc, 32'd7);
    chk("d_ws_cnt", ws_cnt, 1);

    // Abort arriving on the same cycle as the matching fall.
    do_reset();
    frame();
    mode = 2'd0; start = 32'd2; len = 8'd2; ch_mask = 4'b0001; cur_mask = 4'b0001;
    pulse_arm();
    frame();
    vs = 1'b1;
    tick(); tick();
    vs = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick(); tick();
    chk("a_frame_cnt", frame_cnt, 32'd3);
    chk("a_busy", {31'd0, busy}, 32'd0);
    chk("a_ws_cnt", ws_cnt, 0);
    frame(); frame();
    chk("a_still_idle", {31'd0, busy}, 32'd0);

    // Narrow counter: target wraps past the top of the frame counter.
    do_reset();
    frame();
    mode = 2'd1; len = 8'd1; ch_mask = 4'b0000; start4 = 4'd15; period4 = 4'd3;
    sb4_q.push_back(4'd0); sb4_q.push_back(4'd3); sb4_q.push_back(4'd6);
    arm4 = 1'b1;
    tick();
    arm4 = 1'b0;
    repeat (22) frame();
    chk("w_ws4_cnt", ws4_cnt, 3);
    chk("w_sb4_empty", sb4_q.size(), 0);
    chk("w_busy4", {31'd0, busy4}, 32'd1);
    chk("w_main_idle", ws_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
